bit_bbox_detector: RTL and testbench



---
 rtl/bit_bbox_detector_pkg.sv | 19 +
 rtl/bit_frame_timing.sv | 50 +++++
 rtl/bit_bbox_detector.sv | 149 ++++++++++++++
 tb/tb_bit_bbox_detector.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_bbox_detector_pkg.sv
// Shared definitions for the binary-image bounding-box detector: coordinate width,
// FSM encoding, overlay gray level and a saturating coordinate increment.
package bit_bbox_detector_pkg;

    localparam int COORD_W = 11;
    localparam logic [COORD_W-1:0] COORD_MAX = 11'h7FF;
    localparam logic [7:0] OVERLAY_GRAY = 8'h80;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        DONE  = 2'd2
    } bbox_state_t;

    function automatic logic [COORD_W-1:0] coord_sat_inc(input logic [COORD_W-1:0] v);
        return (v == COORD_MAX) ? v : v + COORD_W'(1);
    endfunction

endpackage

// File: rtl/bit_frame_timing.sv
// Frame/line edge detection plus saturating pixel (x) and line (y) counters.
// Edges are combinational from the registered copies; x/y describe the current input pixel.
module bit_frame_timing
    import bit_bbox_detector_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               vsync,
    input  logic               href,
    output logic               frame_start,
    output logic               frame_end,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y
);

    logic               vsync_d;
    logic               href_d;
    logic               armed;
    logic               line_end;
    logic [COORD_W-1:0] x_cnt;
    logic [COORD_W-1:0] y_cnt;

    // armed blocks a false rising edge when vsync is already high as reset releases
    assign frame_start = vsync & ~vsync_d & armed;
    assign frame_end   = ~vsync & vsync_d;
    assign line_end    = ~href & href_d;

    assign x = x_cnt;
    assign y = frame_start ? '0 : y_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d <= 1'b0;
            href_d  <= 1'b0;
            armed   <= 1'b0;
            x_cnt   <= '0;
            y_cnt   <= '0;
        end else begin
            vsync_d <= vsync;
            href_d  <= href;
            armed   <= armed | ~vsync;
            x_cnt   <= href ? coord_sat_inc(x_cnt) : '0;
            if (frame_start)
                y_cnt <= '0;
            else if (line_end)
                y_cnt <= coord_sat_inc(y_cnt);
        end
    end

endmodule

// File: rtl/bit_bbox_detector.sv
// Per-frame bounding box and foreground count of a binary image; video forwarded 1 clk late.
// Optional rectangle overlay on the forwarded gray is built only with BIT_BBOX_OVERLAY_EN.
module bit_bbox_detector
    import bit_bbox_detector_pkg::*;
#(
    parameter logic [10:0] IMG_HDISP = 11'd640,
    parameter logic [10:0] IMG_VDISP = 11'd480,
    parameter int          CNT_W     = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               per_frame_vsync,
    input  logic               per_frame_href,
    input  logic               per_img_Bit,
    output logic               post_frame_vsync,
    output logic               post_frame_href,
    output logic [7:0]         post_img_Gray,
    output logic [10:0]        box_xmin,
    output logic [10:0]        box_xmax,
    output logic [10:0]        box_ymin,
    output logic [10:0]        box_ymax,
    output logic [CNT_W-1:0]   box_pixel_cnt,
    output logic               box_valid,
    output logic               frame_done
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic               frame_start;
    logic               frame_end;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;

    bit_frame_timing u_timing (
        .clk         (clk),
        .rst         (rst),
        .vsync       (per_frame_vsync),
        .href        (per_frame_href),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .x           (x),
        .y           (y)
    );

    bbox_state_t state, state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_start) state_nxt = FRAME;
            FRAME:   if (frame_end)   state_nxt = DONE;
            DONE:    state_nxt = frame_start ? FRAME : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    logic pix_ok;
    logic init;
    logic acc;

    assign pix_ok = per_frame_href & per_img_Bit & (x < IMG_HDISP) & (y < IMG_VDISP);
    // a frame can only begin outside FRAME; the opening pixel seeds the extent directly
    assign init   = frame_start & (state != FRAME);
    assign acc    = pix_ok & (state == FRAME);

    logic [COORD_W-1:0] xmin_w, xmax_w, ymin_w, ymax_w;
    logic [CNT_W-1:0]   cnt_w;
    logic               any_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xmin_w <= COORD_MAX;
            xmax_w <= '0;
            ymin_w <= COORD_MAX;
            ymax_w <= '0;
            cnt_w  <= '0;
            any_w  <= 1'b0;
        end else if (init) begin
            xmin_w <= pix_ok ? x : COORD_MAX;
            xmax_w <= pix_ok ? x : '0;
            ymin_w <= pix_ok ? y : COORD_MAX;
            ymax_w <= pix_ok ? y : '0;
            cnt_w  <= pix_ok ? CNT_W'(1) : '0;
            any_w  <= pix_ok;
        end else if (acc) begin
            if (x < xmin_w) xmin_w <= x;
            if (x > xmax_w) xmax_w <= x;
            if (y < ymin_w) ymin_w <= y;
            if (y > ymax_w) ymax_w <= y;
            if (cnt_w != CNT_MAX) cnt_w <= cnt_w + CNT_W'(1);
            any_w <= 1'b1;
        end
    end

    // results appear together with the frame_done pulse, one clk after DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            box_xmin      <= '0;
            box_xmax      <= '0;
            box_ymin      <= '0;
            box_ymax      <= '0;
            box_pixel_cnt <= '0;
            box_valid     <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= (state == DONE);
            if (state == DONE) begin
                box_valid     <= any_w;
                box_xmin      <= any_w ? xmin_w : '0;
                box_xmax      <= any_w ? xmax_w : '0;
                box_ymin      <= any_w ? ymin_w : '0;
                box_ymax      <= any_w ? ymax_w : '0;
                box_pixel_cnt <= any_w ? cnt_w  : '0;
            end
        end
    end

    logic [7:0] gray_nxt;

`ifdef BIT_BBOX_OVERLAY_EN
    logic on_vedge;
    logic on_hedge;

    assign on_vedge = ((x == box_xmin) || (x == box_xmax)) && (y >= box_ymin) && (y <= box_ymax);
    assign on_hedge = ((y == box_ymin) || (y == box_ymax)) && (x >= box_xmin) && (x <= box_xmax);
    assign gray_nxt = (box_valid && per_frame_href && (on_vedge || on_hedge)) ?
                      OVERLAY_GRAY : {8{per_img_Bit}};
`else
    assign gray_nxt = {8{per_img_Bit}};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_img_Gray    <= '0;
        end else begin
            post_frame_vsync <= per_frame_vsync;
            post_frame_href  <= per_frame_href;
            post_img_Gray    <= gray_nxt;
        end
    end

endmodule

// File: tb/tb_bit_bbox_detector.sv
// Scoreboard bench for bit_bbox_detector: expected boxes and gray pixels are queued at
// stimulus time and popped by a monitor whenever the DUT presents frame_done / post_frame_href.
module tb_bit_bbox_detector;

    localparam int CNT_W = 20;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             per_frame_vsync = 1'b0;
    logic             per_frame_href = 1'b0;
    logic             per_img_Bit = 1'b0;
    logic             post_frame_vsync;
    logic             post_frame_href;
    logic [7:0]       post_img_Gray;
    logic [10:0]      box_xmin, box_xmax, box_ymin, box_ymax;
    logic [CNT_W-1:0] box_pixel_cnt;
    logic             box_valid;
    logic             frame_done;

    bit_bbox_detector #(
        .IMG_HDISP (11'd16),
        .IMG_VDISP (11'd8),
        .CNT_W     (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .per_frame_vsync  (per_frame_vsync),
        .per_frame_href   (per_frame_href),
        .per_img_Bit      (per_img_Bit),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_img_Gray    (post_img_Gray),
        .box_xmin         (box_xmin),
        .box_xmax         (box_xmax),
        .box_ymin         (box_ymin),
        .box_ymax         (box_ymax),
        .box_pixel_cnt    (box_pixel_cnt),
        .box_valid        (box_valid),
        .frame_done       (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int xmin; int xmax; int ymin; int ymax; int cnt; int vld;
    } box_t;

    box_t       sb[$];
    logic [7:0] gq[$];
    int         tests = 0;
    int         fails = 0;
    int         zreq = 0;
    bit         end_req = 1'b0;

    bit img[0:8][0:19];
    bit ov_on = 1'b0;
    int ov_x0 = 0, ov_x1 = 0, ov_y0 = 0, ov_y1 = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_gray(input int x, input int y, input bit b);
`ifdef BIT_BBOX_OVERLAY_EN
        if (ov_on && ((((x == ov_x0) || (x == ov_x1)) && (y >= ov_y0) && (y <= ov_y1)) ||
                      (((y == ov_y0) || (y == ov_y1)) && (x >= ov_x0) && (x <= ov_x1))))
            return 8'h80;
`endif
        return b ? 8'hFF : 8'h00;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_img();
        for (int yy = 0; yy < 9; yy++)
            for (int xx = 0; xx < 20; xx++)
                img[yy][xx] = 1'b0;
    endtask

    task automatic fill(input int x0, input int x1, input int y0, input int y1);
        for (int yy = y0; yy <= y1; yy++)
            for (int xx = x0; xx <= x1; xx++)
                img[yy][xx] = 1'b1;
    endtask

    task automatic drive_line(input int y, input int hlen, input bit chk);
        for (int xx = 0; xx < hlen; xx++) begin
            per_frame_href = 1'b1;
            per_img_Bit    = img[y][xx];
            if (chk) gq.push_back(exp_gray(xx, y, img[y][xx]));
            step(1);
        end
        per_frame_href = 1'b0;
        per_img_Bit    = 1'b0;
        step(4);
    endtask

    task automatic drive_frame(input int nlines, input int hlen, input bit chk);
        per_frame_vsync = 1'b1;
        step(2);
        for (int yy = 0; yy < nlines; yy++) drive_line(yy, hlen, chk);
        per_frame_vsync = 1'b0;
        step(8);
    endtask

    task automatic expect_box(input int x0, input int x1, input int y0, input int y1,
                              input int c, input int v);
        box_t b;
        b.xmin = x0; b.xmax = x1; b.ymin = y0; b.ymax = y1; b.cnt = c; b.vld = v;
        sb.push_back(b);
    endtask

    // Monitor: the only process that performs comparisons.
    bit   rst_prev = 1'b1;
    logic href_prev = 1'b0;
    logic vsync_prev = 1'b0;
    int   zdone = 0;

    always @(negedge clk) begin
        box_t b;
        logic [7:0] g;
        if (!rst && !rst_prev) begin
            check("lat_href", post_frame_href, href_prev);
            check("lat_vsync", post_frame_vsync, vsync_prev);
        end
        rst_prev   = rst;
        href_prev  = per_frame_href;
        vsync_prev = per_frame_vsync;

        if (frame_done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_frame_done: got pulse, expected none (t=%0t)", $time);
            end else begin
                b = sb.pop_front();
                check("box_xmin", box_xmin, b.xmin);
                check("box_xmax", box_xmax, b.xmax);
                check("box_ymin", box_ymin, b.ymin);
                check("box_ymax", box_ymax, b.ymax);
                check("box_pixel_cnt", box_pixel_cnt, b.cnt);
                check("box_valid", box_valid, b.vld);
            end
        end

        if (post_frame_href && gq.size() > 0) begin
            g = gq.pop_front();
            check("post_img_Gray", post_img_Gray, g);
        end

        if (zreq != zdone) begin
            zdone = zreq;
            check("zero_xmin", box_xmin, 0);
            check("zero_xmax", box_xmax, 0);
            check("zero_ymin", box_ymin, 0);
            check("zero_ymax", box_ymax, 0);
            check("zero_cnt", box_pixel_cnt, 0);
            check("zero_valid", box_valid, 0);
            check("zero_frame_done", frame_done, 0);
        end

        if (end_req) begin
            check("scoreboard_drained", sb.size(), 0);
            check("gray_queue_drained", gq.size(), 0);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_img();
        step(3);
        rst = 1'b0;
        step(2);
        zreq++;                     // reset state
        step(2);

        // single foreground pixel, gray forwarding checked (no prior box yet)
        clear_img();
        img[3][5] = 1'b1;
        expect_box(5, 5, 3, 3, 1, 1);
        drive_frame(8, 16, 1'b1);

        // all-zero frame
        clear_img();
        expect_box(0, 0, 0, 0, 0, 0);
        drive_frame(8, 16, 1'b0);

        // block plus stray corner pixel
        clear_img();
        fill(2, 9, 1, 4);
        img[7][15] = 1'b1;
        expect_box(2, 15, 1, 7, 33, 1);
        drive_frame(8, 16, 1'b0);

        // over-long lines and an extra line: out-of-window pixels ignored
        clear_img();
        img[3][5] = 1'b1;
        fill(16, 19, 0, 7);
        img[8][1] = 1'b1;
        expect_box(5, 5, 3, 3, 1, 1);
        drive_frame(9, 20, 1'b0);

        // reset mid-frame after three lines with foreground
        clear_img();
        fill(2, 9, 0, 7);
        per_frame_vsync = 1'b1;
        step(2);
        for (int yy = 0; yy < 3; yy++) drive_line(yy, 16, 1'b0);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
        zreq++;
        for (int yy = 3; yy < 6; yy++) drive_line(yy, 16, 1'b0);
        per_frame_vsync = 1'b0;
        step(8);
        zreq++;                     // partial frame after reset is not reported
        step(2);

        clear_img();
        fill(2, 9, 1, 4);
        expect_box(2, 9, 1, 4, 32, 1);
        drive_frame(8, 16, 1'b0);

        // overlay frame: previous box (2,1)-(9,4)
        clear_img();
        img[0][0]  = 1'b1;
        img[7][15] = 1'b1;
        ov_on = 1'b1; ov_x0 = 2; ov_x1 = 9; ov_y0 = 1; ov_y1 = 4;
        expect_box(0, 15, 0, 7, 2, 1);
        drive_frame(8, 16, 1'b1);
        ov_on = 1'b0;

        step(10);
        end_req = 1'b1;
        step(5);
    end

endmodule
